pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline. It consumes the per-instruction decode controls for the ID-stage instruction, which are generated combinationally by the existing decoder. It keeps a shadow scoreboard of the EX, MEM and WB stages and drives every pipeline-register enable and flush. It also resolves data hazards by forwarding or stalling, and sequences the LSU request/acknowledge handshake, including a wait timeout.

## Interface
Parameters:
- LSU_TIMEOUT, 255: maximum wait cycles for `i_lsu_ack` before a bus error is forced. Range 1..255.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_id_vld  in  1  ID stage holds a real instruction, not a bubble.
- i_id_insn_vld  in  1  decoder reports a legal encoding.
- i_id_rs1_en, i_id_rs2_en  in  1 each  source operands are used.
- i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  in  5 each  register addresses.
- i_id_rd_wren, i_id_mem_rden, i_id_mem_wren  in  1 each  decoder controls.
- i_ex_redirect  in  1  taken branch, JAL or JALR resolved in EX.
- i_lsu_ack  in  1  LSU completes the MEM-stage access.
- o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage register enables.
- o_if_id_flush, o_id_ex_flush  out  1 each  load a bubble into the stage register.
- o_fwd_a_sel, o_fwd_b_sel  out  2 each  EX operand source.
  - 00: register file.
  - 01: EX/MEM result.
  - 10: MEM/WB write data.
- o_lsu_req  out  1  MEM-stage access request.
- o_bus_err  out  1  one-cycle pulse when the LSU times out.
- o_illegal  out  1  one-cycle pulse when an illegal instruction is squashed.

## Operation
- Scoreboard: three entries, EX, MEM and WB. Each entry holds {vld, rd, rd_wren, is_load, is_mem, rs1, rs2}.
  - The scoreboard shifts whenever the pipe is not frozen.
  - The EX entry is loaded from the ID inputs, or cleared when a bubble is inserted.
  - An entry with rd = x0 never creates a hazard.
- Illegal instruction: `i_id_vld & ~i_id_insn_vld` enters EX as a bubble, and `o_illegal` pulses in the cycle the bubble advances.
- LSU FSM states: IDLE, WAIT.
  - `o_lsu_req` = MEM entry vld & is_mem & (state != timed-out).
  - IDLE→WAIT when the request is asserted and `i_lsu_ack` = 0. The wait counter clears.
  - WAIT→IDLE on `i_lsu_ack`, or when the counter reaches LSU_TIMEOUT-1. On timeout, `o_bus_err` pulses and the access is treated as acknowledged.
- freeze = `o_lsu_req & ~i_lsu_ack & ~timeout`. It is the highest priority.
  - All enables are 0 and all flushes are 0.
  - A pending `i_ex_redirect` is held by the frozen EX stage and applied after the freeze releases.
- Redirect (not frozen):
  - `o_pc_en`, `o_if_id_en` and `o_id_ex_en` are 1.
  - `o_if_id_flush` and `o_id_ex_flush` are 1.
  - The EX scoreboard entry loads a bubble.
  - Redirect overrides a data stall.
- Data stall (not frozen, no redirect):
  - `o_pc_en` and `o_if_id_en` are 0.
  - `o_id_ex_flush` is 1.
  - EX, MEM and WB advance.
- Idle case: all enables are 1 and all flushes are 0.

## Timing
- All outputs are combinational from the scoreboard, the FSM state and the current inputs. There are no registered output delays.
- Reset values:
  - Scoreboard entries invalid; FSM in IDLE; counter 0.
  - `o_pc_en` and all other stage enables are 1.
  - Flushes, `o_lsu_req`, `o_bus_err` and `o_illegal` are 0.
  - `o_fwd_*_sel` are 00.
- Reset asserted mid-wait abandons the access immediately; `o_lsu_req` drops asynchronously.
- Zero-wait LSU (ack in the same cycle as the request) costs no stall cycle.
- An ack that arrives in the same cycle as the timeout counts as a normal ack. `o_bus_err` stays 0.
- Forward priority: MEM match over WB match when both match.

## Configuration
- FORWARD_EN defined:
  - `o_fwd_*_sel` are computed from the EX rs1/rs2 against the MEM and WB entries.
  - A data stall occurs only for load-use: the EX entry is_load and its rd matches an enabled ID source. This costs exactly 1 bubble.
- FORWARD_EN undefined:
  - `o_fwd_*_sel` are tied to 00.
  - A data stall occurs whenever an enabled ID source matches the rd of any valid writing entry in EX, MEM or WB. The register file does not bypass.
  - The stall persists until the writer leaves WB: 3 bubbles for back-to-back dependency.

## Structure
- Package pipe_pkg holds:
  - the fwd_sel_e enum (FWD_RF, FWD_MEM, FWD_WB);
  - the lsu_state_e enum;
  - the sb_entry_t struct;
  - the LSU_TIMEOUT default.
- Sub-module lsu_wait_fsm contains the FSM and the timeout counter. It outputs the request, freeze, timeout and bus-error signals.
- Hazard compare and enable priority stay in pipeline_ctrl.

## Test plan
- `lw x5` followed by `add x6,x5,x1`:
  - With FORWARD_EN: 1 cycle `o_pc_en`=0 and `o_id_ex_flush`=1, then `o_fwd_a_sel`=10.
  - Without FORWARD_EN: 3 stall cycles.
- `add x5` then `sub x7,x5,x5`, with FORWARD_EN → no stall; `o_fwd_a_sel` = `o_fwd_b_sel` = 01.
- `addi x0,x0,1` then `add x1,x0,x0` → no stall and fwd 00 in both configurations.
- `sw` with ack delayed 3 cycles → `o_lsu_req` high for 4 cycles and all enables 0 for 3 cycles. A redirect pending in EX applies on the release cycle.
- No ack with LSU_TIMEOUT=4 → `o_bus_err` pulses in the 4th wait cycle and the pipe resumes the next cycle.
- Illegal encoding (`i_id_insn_vld`=0) immediately followed by `i_rst_n` low mid-LSU-wait:
  - `o_illegal` pulses once.
  - After reset, all outputs are at their reset values and the scoreboard is empty.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package pipe_pkg;

  localparam int LSU_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

  // Shadow copy of one downstream stage. rs1/rs2 hold x0 when the operand is unused.
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       rd_wren;
    logic       is_load;
    logic       is_mem;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } sb_entry_t;

  // True when entry e will write register r; x0 is never a dependency.
  function automatic logic writes(sb_entry_t e, logic [4:0] r);
    return e.vld & e.rd_wren & (e.rd != 5'd0) & (e.rd == r);
  endfunction

endpackage

// File: rtl/lsu_wait_fsm.sv
// LSU request/ack sequencer with a bounded wait. A timeout completes the
// access as if acknowledged and raises a one-cycle bus error.
module lsu_wait_fsm
  import pipe_pkg::*;
#(
  parameter int LSU_TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic access,
  input  logic ack,
  output logic req,
  output logic freeze,
  output logic timeout,
  output logic bus_err
);

  lsu_state_e state;
  logic [7:0] cnt;

  // A same-cycle ack wins over the timeout, so timeout is masked by ack.
  assign timeout = access & (state == LSU_WAIT) & (cnt == 8'(LSU_TIMEOUT - 1)) & ~ack;
  assign req     = access & ~timeout;
  assign freeze  = req & ~ack;
  assign bus_err = timeout;

  // Track the outstanding access and count wait cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        LSU_IDLE: if (req & ~ack) begin
          state <= LSU_WAIT;
          cnt   <= '0;
        end
        LSU_WAIT: if (ack | timeout | ~access) state <= LSU_IDLE;
                  else cnt <= cnt + 8'd1;
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Define FORWARD_EN to enable EX-operand forwarding (load-use stall only);
// without it every RAW dependency stalls until the writer leaves WB.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int LSU_TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_id_vld,
  input  logic       i_id_insn_vld,
  input  logic       i_id_rs1_en,
  input  logic       i_id_rs2_en,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic [4:0] i_id_rd_addr,
  input  logic       i_id_rd_wren,
  input  logic       i_id_mem_rden,
  input  logic       i_id_mem_wren,
  input  logic       i_ex_redirect,
  input  logic       i_lsu_ack,
  output logic       o_pc_en,
  output logic       o_if_id_en,
  output logic       o_id_ex_en,
  output logic       o_ex_mem_en,
  output logic       o_mem_wb_en,
  output logic       o_if_id_flush,
  output logic       o_id_ex_flush,
  output logic [1:0] o_fwd_a_sel,
  output logic [1:0] o_fwd_b_sel,
  output logic       o_lsu_req,
  output logic       o_bus_err,
  output logic       o_illegal
);

  sb_entry_t  sb_ex, sb_mem, sb_wb, sb_ex_nxt;
  fwd_sel_e   fwd_a, fwd_b;
  logic       id_real, stall, freeze, lsu_timeout;
  logic [4:0] rs1_id, rs2_id;

  // Illegal encodings never create hazards; they only become a bubble.
  assign id_real = i_id_vld & i_id_insn_vld;
  assign rs1_id  = i_id_rs1_en ? i_id_rs1_addr : 5'd0;
  assign rs2_id  = i_id_rs2_en ? i_id_rs2_addr : 5'd0;

`ifdef FORWARD_EN
  // Only a load in EX cannot be bypassed in time.
  assign stall = id_real & sb_ex.is_load & (writes(sb_ex, rs1_id) | writes(sb_ex, rs2_id));

  // MEM is the younger producer, so it takes priority over WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (sb_ex.vld) begin
      if (writes(sb_mem, sb_ex.rs1))     fwd_a = FWD_MEM;
      else if (writes(sb_wb, sb_ex.rs1)) fwd_a = FWD_WB;
      if (writes(sb_mem, sb_ex.rs2))     fwd_b = FWD_MEM;
      else if (writes(sb_wb, sb_ex.rs2)) fwd_b = FWD_WB;
    end
  end
`else
  // No bypass anywhere: hold ID until every in-flight writer has retired.
  assign stall = id_real & (writes(sb_ex, rs1_id)  | writes(sb_ex, rs2_id)  |
                            writes(sb_mem, rs1_id) | writes(sb_mem, rs2_id) |
                            writes(sb_wb, rs1_id)  | writes(sb_wb, rs2_id));
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  assign o_fwd_a_sel = fwd_a;
  assign o_fwd_b_sel = fwd_b;

  lsu_wait_fsm #(.LSU_TIMEOUT(LSU_TIMEOUT)) u_lsu (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .access  (sb_mem.vld & sb_mem.is_mem),
    .ack     (i_lsu_ack),
    .req     (o_lsu_req),
    .freeze  (freeze),
    .timeout (lsu_timeout),
    .bus_err (o_bus_err)
  );

  // Priority: freeze, then redirect, then data stall. A redirect held by a
  // frozen EX is simply seen again once the freeze drops.
  assign o_pc_en       = ~freeze & (i_ex_redirect | ~stall);
  assign o_if_id_en    = ~freeze & (i_ex_redirect | ~stall);
  assign o_id_ex_en    = ~freeze;
  assign o_ex_mem_en   = ~freeze;
  assign o_mem_wb_en   = ~freeze;
  assign o_if_id_flush = ~freeze & i_ex_redirect;
  assign o_id_ex_flush = ~freeze & (i_ex_redirect | stall | (i_id_vld & ~i_id_insn_vld));
  assign o_illegal     = ~freeze & ~i_ex_redirect & i_id_vld & ~i_id_insn_vld;

  // Next EX entry: the ID instruction, or a bubble on redirect/stall/illegal.
  always_comb begin
    sb_ex_nxt = '0;
    if (id_real & ~i_ex_redirect & ~stall) begin
      sb_ex_nxt.vld     = 1'b1;
      sb_ex_nxt.rd      = i_id_rd_addr;
      sb_ex_nxt.rd_wren = i_id_rd_wren;
      sb_ex_nxt.is_load = i_id_mem_rden;
      sb_ex_nxt.is_mem  = i_id_mem_rden | i_id_mem_wren;
      sb_ex_nxt.rs1     = rs1_id;
      sb_ex_nxt.rs2     = rs2_id;
    end
  end

  // Scoreboard shifts in lockstep with the pipe; frozen stages hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (!freeze) begin
      sb_ex  <= sb_ex_nxt;
      sb_mem <= sb_ex;
      sb_wb  <= sb_mem;
    end
  end

  // WB only ever sources its destination; bus_err already carries the timeout.
  logic unused_sb;
  assign unused_sb = ^{sb_wb.is_load, sb_wb.is_mem, sb_wb.rs1, sb_wb.rs2, lsu_timeout};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (LSU_TIMEOUT=4). Expectations follow the
// FORWARD_EN setting of the build.
module tb_pipeline_ctrl;

  logic       i_clk, i_rst_n;
  logic       i_id_vld, i_id_insn_vld, i_id_rs1_en, i_id_rs2_en;
  logic [4:0] i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
  logic       i_id_rd_wren, i_id_mem_rden, i_id_mem_wren, i_ex_redirect, i_lsu_ack;
  logic       o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
  logic       o_if_id_flush, o_id_ex_flush, o_lsu_req, o_bus_err, o_illegal;
  logic [1:0] o_fwd_a_sel, o_fwd_b_sel;

  pipeline_ctrl #(.LSU_TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_vld(i_id_vld), .i_id_insn_vld(i_id_insn_vld),
    .i_id_rs1_en(i_id_rs1_en), .i_id_rs2_en(i_id_rs2_en), .i_id_rs1_addr(i_id_rs1_addr),
    .i_id_rs2_addr(i_id_rs2_addr), .i_id_rd_addr(i_id_rd_addr), .i_id_rd_wren(i_id_rd_wren),
    .i_id_mem_rden(i_id_mem_rden), .i_id_mem_wren(i_id_mem_wren), .i_ex_redirect(i_ex_redirect),
    .i_lsu_ack(i_lsu_ack), .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
    .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_flush(o_id_ex_flush), .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel),
    .o_lsu_req(o_lsu_req), .o_bus_err(o_bus_err), .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       vld, ivld, r1e, r2e;
    logic [4:0] r1, r2, rd;
    logic       wr, mrd, mwr, redir, ack;
  } stim_t;

  typedef struct {
    stim_t       stim;
    logic [13:0] want;
  } vec_t;

  // Output word: {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex flush | fwd_a | fwd_b | req,bus_err,illegal}
  localparam logic [13:0] I0   = 14'b11111_00_00_00_000;
  localparam logic [13:0] I1   = 14'b11111_00_00_00_100;
  localparam logic [13:0] S0   = 14'b00111_01_00_00_000;
  localparam logic [13:0] S1   = 14'b00111_01_00_00_100;
  localparam logic [13:0] FZ   = 14'b00000_00_00_00_100;
  localparam logic [13:0] RD0  = 14'b11111_11_00_00_000;
  localparam logic [13:0] RD1  = 14'b11111_11_00_00_100;
  localparam logic [13:0] TMO  = 14'b11111_00_00_00_010;
  localparam logic [13:0] ILL  = 14'b11111_01_00_00_001;
  localparam logic [13:0] FAWB = 14'b11111_00_10_00_000;
  localparam logic [13:0] FMEM = 14'b11111_00_01_01_000;

  logic [13:0] got;
  assign got = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
                o_if_id_flush, o_id_ex_flush, o_fwd_a_sel, o_fwd_b_sel,
                o_lsu_req, o_bus_err, o_illegal};

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  function automatic stim_t mk(logic vld, logic ivld, logic r1e, logic r2e, logic [4:0] r1,
                               logic [4:0] r2, logic [4:0] rd, logic wr, logic mrd, logic mwr);
    stim_t s;
    s = '0;
    s.vld = vld; s.ivld = ivld; s.r1e = r1e; s.r2e = r2e;
    s.r1 = r1; s.r2 = r2; s.rd = rd; s.wr = wr; s.mrd = mrd; s.mwr = mwr;
    return s;
  endfunction

  function automatic stim_t alu(logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
    return mk(1, 1, 1, 1, r1, r2, rd, 1, 0, 0);
  endfunction
  function automatic stim_t ld(logic [4:0] rd, logic [4:0] r1);
    return mk(1, 1, 1, 0, r1, 5'd0, rd, 1, 1, 0);
  endfunction
  function automatic stim_t st(logic [4:0] r1, logic [4:0] r2);
    return mk(1, 1, 1, 1, r1, r2, 5'd0, 0, 0, 1);
  endfunction
  function automatic stim_t bub();
    return '0;
  endfunction
  function automatic stim_t w(stim_t s, logic redir, logic ack);
    s.redir = redir;
    s.ack = ack;
    return s;
  endfunction

  // Table rows run with a zero-wait LSU.
  function automatic void row(stim_t s, logic redir, logic [13:0] want);
    vec_t v;
    v.stim = w(s, redir, 1'b1);
    v.want = want;
    tbl.push_back(v);
  endfunction

  task automatic drive(stim_t s);
    i_id_vld = s.vld; i_id_insn_vld = s.ivld; i_id_rs1_en = s.r1e; i_id_rs2_en = s.r2e;
    i_id_rs1_addr = s.r1; i_id_rs2_addr = s.r2; i_id_rd_addr = s.rd;
    i_id_rd_wren = s.wr; i_id_mem_rden = s.mrd; i_id_mem_wren = s.mwr;
    i_ex_redirect = s.redir; i_lsu_ack = s.ack;
  endtask

  task automatic check(string nm, logic [13:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b (en5 fl2 fa2 fb2 req berr ill)", nm, got, want);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs sampled 3 units later.
  task automatic drive_chk(stim_t s, logic [13:0] want, string nm);
    drive(s);
    #3;
    check(nm, want);
  endtask

  task automatic step(stim_t s, logic [13:0] want, string nm);
    drive_chk(s, want, nm);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // lw x5 ; add x6,x5,x1
    row(ld(5, 1), 0, I0);
`ifdef FORWARD_EN
    row(alu(6, 5, 1), 0, S0);
    row(alu(6, 5, 1), 0, I1);
    row(bub(), 0, FAWB);
    row(bub(), 0, I0); row(bub(), 0, I0); row(bub(), 0, I0);
`else
    row(alu(6, 5, 1), 0, S0);
    row(alu(6, 5, 1), 0, S1);
    row(alu(6, 5, 1), 0, S0);
    row(alu(6, 5, 1), 0, I0);
    row(bub(), 0, I0); row(bub(), 0, I0); row(bub(), 0, I0);
`endif
    // add x5,x1,x2 ; sub x7,x5,x5
    row(alu(5, 1, 2), 0, I0);
`ifdef FORWARD_EN
    row(alu(7, 5, 5), 0, I0);
    row(bub(), 0, FMEM);
    row(bub(), 0, I0); row(bub(), 0, I0);
`else
    row(alu(7, 5, 5), 0, S0);
    row(alu(7, 5, 5), 0, S0);
    row(alu(7, 5, 5), 0, S0);
    row(alu(7, 5, 5), 0, I0);
    row(bub(), 0, I0); row(bub(), 0, I0); row(bub(), 0, I0);
`endif
    // addi x0,x0,1 ; add x1,x0,x0 : x0 never a hazard nor forwarded
    row(mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0), 0, I0);
    row(alu(1, 0, 0), 0, I0);
    row(bub(), 0, I0); row(bub(), 0, I0); row(bub(), 0, I0);
    // redirect overrides a load-use stall
    row(ld(5, 1), 0, I0);
    row(alu(6, 5, 0), 1, RD0);
    row(bub(), 0, I1);
    row(bub(), 0, I0);

    // reset state
    drive(bub());
    i_rst_n = 1'b0;
    #2;
    check("reset_async", I0);
    @(posedge i_clk); @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    drive_chk(bub(), I0, "reset_release");
    @(posedge i_clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].stim, tbl[i].want, $sformatf("tbl%0d", i));

    // sw with ack 3 cycles late; redirect from EX held through the freeze
    step(w(st(1, 2), 0, 0), I0, "sw_id");
    step(w(mk(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), 0, 0), I0, "br_id");
    for (int i = 0; i < 3; i++)
      step(w(alu(9, 3, 4), 1, 0), FZ, $sformatf("sw_freeze%0d", i));
    step(w(alu(9, 3, 4), 1, 1), RD1, "sw_release_redirect");
    step(bub(), I0, "sw_after");
    step(bub(), I0, "sw_drain");

    // no ack: bus error in the 4th wait cycle, pipe moves on
    step(ld(10, 1), I0, "to_id");
    step(bub(), I0, "to_ex");
    for (int i = 0; i < 4; i++)
      step(bub(), FZ, $sformatf("to_freeze%0d", i));
    step(bub(), TMO, "to_buserr");
    step(bub(), I0, "to_resume");
    step(bub(), I0, "to_drain");

    // ack on the timeout cycle is a normal ack
    step(ld(11, 1), I0, "ackto_id");
    step(bub(), I0, "ackto_ex");
    for (int i = 0; i < 4; i++)
      step(bub(), FZ, $sformatf("ackto_freeze%0d", i));
    step(w(bub(), 0, 1), I1, "ackto_ack");
    step(bub(), I0, "ackto_resume");
    step(bub(), I0, "ackto_drain");

    // illegal encoding, then reset in the middle of an LSU wait
    step(st(1, 2), I0, "ill_sw");
    step(mk(1, 0, 1, 1, 5'd5, 5'd6, 5'd7, 1, 0, 0), ILL, "ill_pulse");
    step(bub(), FZ, "ill_wait0");
    drive_chk(bub(), FZ, "ill_wait1");
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_wait", I0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step(alu(3, 1, 2), I0, "post_rst_id");
    step(bub(), I0, "post_rst_ex");
    step(bub(), I0, "post_rst_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
